// File: rtl/bus_interface_unit_pkg.sv
// Shared encodings for the bus interface unit:
// trans/size codes, prot bit indices, FSM states.
package bus_interface_unit_pkg;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

  localparam int PROT_DATA = 0;
  localparam int PROT_PRIV = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT
  } state_t;

endpackage

// File: rtl/bus_interface_unit_if.sv
// Memory bus between initiator (master) and responder (slave).
// addr/wdata/write/size/prot/trans out; rdata/data_valid/abort back.
interface bus_interface_unit_if;

  logic [31:0] addr;
  logic [31:0] wdata;
  logic        write;
  logic        size;
  logic [1:0]  prot;
  logic [1:0]  trans;
  logic [31:0] rdata;
  logic        data_valid;
  logic        abort;

  modport master (
    output addr, wdata, write, size, prot, trans,
    input  rdata, data_valid, abort
  );

  modport slave (
    input  addr, wdata, write, size, prot, trans,
    output rdata, data_valid, abort
  );

endinterface

// File: rtl/bus_read_formatter.sv
// Size handling: byte-read zero extension and byte-store lane
// replication. Ports: rd_size/rdata_in -> rdata_out, wr_size/wdata_in -> wdata_out.
module bus_read_formatter
  import bus_interface_unit_pkg::*;
(
  input  logic        rd_size,
  input  logic [31:0] rdata_in,
  input  logic        wr_size,
  input  logic [31:0] wdata_in,
  output logic [31:0] rdata_out,
  output logic [31:0] wdata_out
);

  always_comb begin
    rdata_out = rdata_in;
    wdata_out = wdata_in;
    if (rd_size == SIZE_BYTE)
      rdata_out = {24'b0, rdata_in[7:0]};
    // responder picks the lane using size and addr
    if (wr_size == SIZE_BYTE)
      wdata_out = {4{wdata_in[7:0]}};
  end

endmodule

// File: rtl/bus_interface_unit.sv
// Initiator bus unit: arbitrates fetch/data requests onto the bus.
// Ports: clk, rst, priv, fetch f_*, data d_*, bus (master modport).
module bus_interface_unit
  import bus_interface_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        priv,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_ack,
  output logic        f_valid,
  output logic [31:0] f_rdata,
  output logic        f_abort,
  input  logic        d_req,
  input  logic        d_write,
  input  logic        d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        d_abort,
  bus_interface_unit_if.master bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST =
    CW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [31:0]   addr_q, wdata_q;
  logic          write_q, size_q, data_q, seq_q;
  logic [1:0]    prot_q;

  logic          timeout, done, accept;
  logic          take_d, take_f, issue, seq_nx;
  logic          nx_write, nx_size, abort_c;
  logic [31:0]   nx_addr, nx_wdata, rd_fmt, rdata_c;

  bus_read_formatter u_fmt (
    .rd_size   (size_q),
    .rdata_in  (bus.rdata),
    .wr_size   (d_size),
    .wdata_in  (d_wdata),
    .rdata_out (rd_fmt),
    .wdata_out (nx_wdata)
  );

  always_comb begin
    timeout = (state == S_WAIT) && !bus.data_valid
              && (cnt == TO_LAST);
    done    = (state == S_WAIT)
              && (bus.data_valid || timeout);
    // a completing WAIT may immediately issue again
    accept  = !rst && ((state == S_IDLE) ||
              ((state == S_WAIT) && bus.data_valid));
    take_d  = accept && d_req;
    take_f  = accept && f_req && !d_req;
    issue   = take_d || take_f;
    d_ack   = take_d;
    f_ack   = take_f;

    nx_addr  = take_d ? d_addr : f_addr;
    nx_write = take_d && d_write;
    nx_size  = take_d ? d_size : SIZE_WORD;
    seq_nx   = (state == S_WAIT)
               && (data_q == take_d)
               && (write_q == nx_write)
               && (size_q == SIZE_WORD)
               && (nx_size == SIZE_WORD)
               && (nx_addr == addr_q + 32'd4);

    abort_c = timeout || bus.abort;
    rdata_c = (abort_c || write_q) ? 32'b0 : rd_fmt;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (issue) state_nx = S_ADDR;
      S_ADDR: state_nx = S_WAIT;
      S_WAIT: begin
        if (issue)     state_nx = S_ADDR;
        else if (done) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      size_q  <= 1'b0;
      data_q  <= 1'b0;
      seq_q   <= 1'b0;
      prot_q  <= '0;
      f_valid <= 1'b0;
      f_abort <= 1'b0;
      f_rdata <= '0;
      d_valid <= 1'b0;
      d_abort <= 1'b0;
      d_rdata <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state == S_WAIT) ? cnt + 1'b1 : '0;
      if (issue) begin
        addr_q            <= nx_addr;
        write_q           <= nx_write;
        size_q            <= nx_size;
        data_q            <= take_d;
        seq_q             <= seq_nx;
        wdata_q           <= take_d ? nx_wdata : 32'b0;
        prot_q[PROT_PRIV] <= priv;
        prot_q[PROT_DATA] <= take_d;
      end
      f_valid <= done && !data_q;
      d_valid <= done && data_q;
      if (done && !data_q) begin
        f_abort <= abort_c;
        f_rdata <= rdata_c;
      end
      if (done && data_q) begin
        d_abort <= abort_c;
        d_rdata <= rdata_c;
      end
    end
  end

  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;
  assign bus.write = write_q;
  assign bus.size  = size_q;
  assign bus.prot  = prot_q;
  assign bus.trans = (state != S_ADDR) ? TRANS_IDLE :
                     seq_q ? TRANS_SEQ : TRANS_NONSEQ;

endmodule

// File: tb/tb_bus_interface_unit.sv
// Directed bench for bus_interface_unit with a small bus responder
// and a completion scoreboard.
module tb_bus_interface_unit;
  import bus_interface_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        priv = 1'b0;
  logic        f_req = 1'b0;
  logic [31:0] f_addr = '0;
  logic        d_req = 1'b0;
  logic        d_write = 1'b0;
  logic        d_size = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        f_ack, f_valid, f_abort;
  logic        d_ack, d_valid, d_abort;
  logic [31:0] f_rdata, d_rdata;

  bus_interface_unit_if bus ();

  bus_interface_unit #(.TIMEOUT_CYCLES(15)) dut (
    .clk     (clk),
    .rst     (rst),
    .priv    (priv),
    .f_req   (f_req),
    .f_addr  (f_addr),
    .f_ack   (f_ack),
    .f_valid (f_valid),
    .f_rdata (f_rdata),
    .f_abort (f_abort),
    .d_req   (d_req),
    .d_write (d_write),
    .d_size  (d_size),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_ack   (d_ack),
    .d_valid (d_valid),
    .d_rdata (d_rdata),
    .d_abort (d_abort),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int txn = 0;

  typedef struct {
    bit          is_data;
    logic [31:0] rdata;
    bit          abort;
    bit          chk_rdata;
    int          cyc;
    int          id;
  } exp_t;

  exp_t sbq[$];
  logic [31:0] mem [logic [31:0]];
  int resp_delay = 0;
  bit resp_abort = 1'b0;

  logic [139:0] outs;
  assign outs = {f_ack, f_valid, f_rdata, f_abort,
                 d_ack, d_valid, d_rdata, d_abort,
                 bus.addr, bus.wdata, bus.write,
                 bus.size, bus.prot, bus.trans};

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input bit is_data,
                      input logic [31:0] rd,
                      input bit ab, input bit cr,
                      input int c);
    exp_t e;
    e.is_data = is_data;
    e.rdata = rd;
    e.abort = ab;
    e.chk_rdata = cr;
    e.cyc = c;
    e.id = txn;
    txn++;
    sbq.push_back(e);
  endtask

  function automatic logic [31:0] mem_rd(logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (mem.exists(w)) return mem[w];
    return w ^ 32'h5A5A_0000;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // responder: answers delay cycles after the WAIT starts
  initial begin : responder
    int cnt;
    bit armed;
    logic [31:0] ra;
    cnt = 0;
    armed = 1'b0;
    ra = '0;
    bus.data_valid = 1'b0;
    bus.abort = 1'b0;
    bus.rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.data_valid = 1'b0;
      bus.abort = 1'b0;
      if (bus.trans != TRANS_IDLE) begin
        armed = 1'b1;
        cnt = resp_delay;
        ra = bus.addr;
      end else if (armed) begin
        if (cnt == 0) begin
          bus.data_valid = 1'b1;
          bus.abort = resp_abort;
          bus.rdata = mem_rd(ra);
          armed = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  initial forever begin : monitor
    exp_t e;
    @(negedge clk);
    if (f_valid && d_valid) begin
      chk("valid_overlap", {f_valid, d_valid}, 2'b00);
    end else if (f_valid || d_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_valid", {d_valid, f_valid}, 2'b00);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("port_t%0d", e.id), d_valid, e.is_data);
        chk($sformatf("abort_t%0d", e.id),
            d_valid ? d_abort : f_abort, e.abort);
        if (e.chk_rdata)
          chk($sformatf("rdata_t%0d", e.id),
              d_valid ? d_rdata : f_rdata, e.rdata);
        chk($sformatf("cycle_t%0d", e.id), cyc, e.cyc);
      end
    end
  end

  task automatic run_fetch1(input string tag);
    priv = 1'b1;
    f_addr = 32'h100;
    f_req = 1'b1;
    #1;
    chk({tag, "_f_ack"}, f_ack, 1'b1);
    chk({tag, "_d_ack"}, d_ack, 1'b0);
    push(1'b0, 32'h1234_5678, 1'b0, 1'b1, cyc + 3);
    tick();
    f_req = 1'b0;
    chk({tag, "_trans"}, bus.trans, TRANS_NONSEQ);
    chk({tag, "_addr"}, bus.addr, 32'h100);
    chk({tag, "_prot"}, bus.prot, 2'b10);
    tick();
    chk({tag, "_wait_trans"}, bus.trans, TRANS_IDLE);
    repeat (4) tick();
  endtask

  logic [31:0] fa [3];
  logic [1:0]  ft [3];

  initial begin
    mem[32'h100] = 32'h1234_5678;
    mem[32'h300] = 32'hAABB_CCDD;
    mem[32'h400] = 32'hCAFE_F00D;
    mem[32'h500] = 32'h0BAD_C0DE;
    mem[32'h600] = 32'hDEAD_BEEF;
    fa[0] = 32'h200;
    fa[1] = 32'h204;
    fa[2] = 32'h20C;
    ft[0] = TRANS_NONSEQ;
    ft[1] = TRANS_SEQ;
    ft[2] = TRANS_NONSEQ;

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_outputs", outs, '0);

    run_fetch1("fetch1");

    // simultaneous requests: data first, fetch in data WAIT
    d_req = 1'b1;
    d_write = 1'b0;
    d_size = SIZE_WORD;
    d_addr = 32'h400;
    f_req = 1'b1;
    f_addr = 32'h500;
    #1;
    chk("arb_d_ack", d_ack, 1'b1);
    chk("arb_f_ack0", f_ack, 1'b0);
    push(1'b1, 32'hCAFE_F00D, 1'b0, 1'b1, cyc + 3);
    tick();
    d_req = 1'b0;
    chk("arb_f_ack_addr", f_ack, 1'b0);
    chk("arb_d_trans", bus.trans, TRANS_NONSEQ);
    chk("arb_d_prot", bus.prot, 2'b11);
    tick();
    #1;
    chk("arb_f_ack_wait", f_ack, 1'b1);
    push(1'b0, 32'h0BAD_C0DE, 1'b0, 1'b1, cyc + 3);
    tick();
    f_req = 1'b0;
    chk("arb_f_trans", bus.trans, TRANS_NONSEQ);
    chk("arb_f_addr", bus.addr, 32'h500);
    chk("arb_f_prot", bus.prot, 2'b10);
    repeat (5) tick();

    // streaming fetches
    f_req = 1'b1;
    f_addr = fa[0];
    #1;
    chk("seq_ack0", f_ack, 1'b1);
    push(1'b0, mem_rd(fa[0]), 1'b0, 1'b1, cyc + 3);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("seq_trans%0d", i), bus.trans, ft[i]);
      chk($sformatf("seq_addr%0d", i), bus.addr, fa[i]);
      if (i < 2) f_addr = fa[i+1];
      else f_req = 1'b0;
      tick();
      chk($sformatf("seq_wait%0d", i), bus.trans, TRANS_IDLE);
      if (i < 2) begin
        #1;
        chk($sformatf("seq_ack%0d", i + 1), f_ack, 1'b1);
        push(1'b0, mem_rd(fa[i+1]), 1'b0, 1'b1, cyc + 3);
      end
    end
    repeat (4) tick();

    // byte load
    d_req = 1'b1;
    d_write = 1'b0;
    d_size = SIZE_BYTE;
    d_addr = 32'h301;
    #1;
    chk("bload_ack", d_ack, 1'b1);
    push(1'b1, 32'h0000_00DD, 1'b0, 1'b1, cyc + 3);
    tick();
    d_req = 1'b0;
    chk("bload_size", bus.size, SIZE_BYTE);
    chk("bload_addr", bus.addr, 32'h301);
    chk("bload_write", bus.write, 1'b0);
    repeat (4) tick();

    // byte store
    d_req = 1'b1;
    d_write = 1'b1;
    d_size = SIZE_BYTE;
    d_addr = 32'h310;
    d_wdata = 32'h1234_565A;
    #1;
    chk("bstore_ack", d_ack, 1'b1);
    push(1'b1, 32'h0, 1'b0, 1'b0, cyc + 3);
    tick();
    d_req = 1'b0;
    d_write = 1'b0;
    chk("bstore_wdata", bus.wdata, 32'h5A5A_5A5A);
    chk("bstore_size", bus.size, SIZE_BYTE);
    chk("bstore_write", bus.write, 1'b1);
    chk("bstore_trans", bus.trans, TRANS_NONSEQ);
    repeat (4) tick();

    // timeout after 15 silent WAIT cycles; late response ignored
    resp_delay = 20;
    d_req = 1'b1;
    d_size = SIZE_WORD;
    d_addr = 32'h400;
    #1;
    chk("tmo_ack", d_ack, 1'b1);
    push(1'b1, 32'h0, 1'b1, 1'b1, cyc + 17);
    tick();
    d_req = 1'b0;
    tick();
    resp_delay = 0;
    repeat (16) tick();
    chk("tmo_trans_idle", bus.trans, TRANS_IDLE);
    repeat (6) tick();

    // responder abort on a fetch
    resp_abort = 1'b1;
    f_req = 1'b1;
    f_addr = 32'h600;
    #1;
    chk("abort_ack", f_ack, 1'b1);
    push(1'b0, 32'h0, 1'b1, 1'b1, cyc + 3);
    tick();
    f_req = 1'b0;
    tick();
    resp_abort = 1'b0;
    repeat (4) tick();

    // reset while waiting drops the transaction
    resp_delay = 3;
    f_req = 1'b1;
    f_addr = 32'h100;
    #1;
    chk("rstmid_ack", f_ack, 1'b1);
    tick();
    f_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    resp_delay = 0;
    chk("rstmid_outputs", outs, '0);
    repeat (5) tick();

    run_fetch1("refetch");

    for (int i = 0; i < 50 && sbq.size() > 0; i++) tick();
    chk("scoreboard_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
